pc_stack_unit: RTL and testbench

Program-counter register and hardware return-address stack, sitting directly downstream of the instruction controller. Each cycle it consumes the controller's PC-source selects and push/pop requests, computes the next fetch address, and keeps a LIFO of return addresses for JSB/RET. Its `pc` output drives the instruction-memory address.

---
 rtl/pc_stack_unit_if.sv | 30 +++
 rtl/pc_stack_unit.sv | 72 +++++++
 tb/tb_pc_stack_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: controller-to-PC/stack bundle; master is the instruction controller.
interface pc_stack_unit_if #(
  parameter int ADDR_W   = 12,
  parameter int OFFSET_W = 8,
  parameter int DEPTH    = 8
);
  logic                       stall;
  logic                       sel_PCSrc_plus1;
  logic                       sel_PCSrc_offset;
  logic                       sel_PCSrc_const;
  logic                       sel_PCSrc_stack;
  logic                       push_stack;
  logic                       pop_stack;
  logic [OFFSET_W-1:0]        offset;
  logic [ADDR_W-1:0]          jump_addr;
  logic [ADDR_W-1:0]          pc;
  logic [$clog2(DEPTH):0]     stack_depth;
  logic                       stack_overflow;
  logic                       stack_underflow;
  modport master (
    output stall, sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const, sel_PCSrc_stack,
           push_stack, pop_stack, offset, jump_addr,
    input  pc, stack_depth, stack_overflow, stack_underflow
  );
  modport slave (
    input  stall, sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const, sel_PCSrc_stack,
           push_stack, pop_stack, offset, jump_addr,
    output pc, stack_depth, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: PC register plus LIFO return-address stack.
// Define PC_STACK_GUARD_EN to drop overflowing pushes / empty pops and raise sticky flags.
module pc_stack_unit #(
  parameter int              ADDR_W   = 12,
  parameter int              OFFSET_W = 8,
  parameter int              DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst_n,
  pc_stack_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, pc_off, top;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [SW-1:0]     sp_q, sp_d, sp_inc, sp_dec;
  logic [AW-1:0]     sp_lo, top_idx;
  logic              full, empty, push, pop, ovf_q, ovf_d, unf_q, unf_d;
  assign push    = bus.push_stack & ~bus.stall;
  assign pop     = bus.pop_stack & ~bus.stall;
  assign sp_lo   = sp_q[AW-1:0];
  assign top_idx = sp_lo - AW'(1);
  assign top     = mem_q[top_idx];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_off  = pc_q + ADDR_W'($signed(bus.offset));
`ifdef PC_STACK_GUARD_EN
  assign full   = sp_q == SW'(DEPTH);
  assign empty  = sp_q == '0;
  assign sp_inc = sp_q + SW'(1);
  assign sp_dec = sp_q - SW'(1);
`else
  // sp wraps modulo DEPTH, so its top bit stays 0 and the stack silently overwrites.
  assign full   = 1'b0;
  assign empty  = 1'b0;
  assign sp_inc = {1'b0, sp_lo + AW'(1)};
  assign sp_dec = {1'b0, top_idx};
`endif
  always_comb begin
    pc_d = bus.stall            ? pc_q :
           bus.sel_PCSrc_stack  ? (empty ? pc_inc : top) :
           bus.sel_PCSrc_const  ? bus.jump_addr :
           bus.sel_PCSrc_offset ? pc_off :
           bus.sel_PCSrc_plus1  ? pc_inc : pc_q;
    sp_d = (push && !pop && !full) ? sp_inc :
           (pop && !push && !empty) ? sp_dec : sp_q;
    mem_d = mem_q;
    if (push && (pop ? !empty : !full)) mem_d[pop ? top_idx : sp_lo] = pc_inc;
    ovf_d = ovf_q | (push & ~pop & full);
    unf_d = unf_q | (~bus.stall & (bus.pop_stack | bus.sel_PCSrc_stack) & empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      mem_q <= '{default: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      mem_q <= mem_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.pc              = pc_q;
  assign bus.stack_depth     = sp_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: table-driven vectors plus wrap/overflow/reset sequences, scoreboard-checked.
module tb_pc_stack_unit;
  localparam int AW = 12;
  localparam int OW = 8;
  localparam int D  = 8;
`ifdef PC_STACK_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif
  typedef struct {
    logic st, ss, sc, so, p1, pu, po;
    logic [OW-1:0] off;
    logic [AW-1:0] jmp;
    logic [AW-1:0] pc;
    logic [3:0] dep;
    logic ovf, unf;
  } vec_t;
  typedef struct {
    logic [AW-1:0] pc;
    logic [3:0] dep;
    logic ovf, unf;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  pc_stack_unit_if #(.ADDR_W(AW), .OFFSET_W(OW), .DEPTH(D)) bus();
  pc_stack_unit #(.ADDR_W(AW), .OFFSET_W(OW), .DEPTH(D), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  function automatic vec_t v(input logic st, ss, sc, so, p1, pu, po, input logic [OW-1:0] off,
                             input logic [AW-1:0] jmp, pc, input logic [3:0] dep,
                             input logic ovf = 1'b0, unf = 1'b0);
    vec_t r;
    r = '{st, ss, sc, so, p1, pu, po, off, jmp, pc, dep, ovf, unf};
    return r;
  endfunction
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input vec_t x);
    bus.stall = x.st; bus.sel_PCSrc_stack = x.ss; bus.sel_PCSrc_const = x.sc;
    bus.sel_PCSrc_offset = x.so; bus.sel_PCSrc_plus1 = x.p1;
    bus.push_stack = x.pu; bus.pop_stack = x.po; bus.offset = x.off; bus.jump_addr = x.jmp;
  endtask
  task automatic step(input vec_t x, input string n);
    exp_t e;
    drive(x);
    sb.push_back('{x.pc, x.dep, x.ovf, x.unf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({n, ".pc"}, 32'(bus.pc), 32'(e.pc));
    cmp({n, ".depth"}, 32'(bus.stack_depth), 32'(e.dep));
    cmp({n, ".ovf"}, 32'(bus.stack_overflow), 32'(e.ovf));
    cmp({n, ".unf"}, 32'(bus.stack_underflow), 32'(e.unf));
  endtask
  task automatic do_reset;
    drive(v(0,0,0,0,0,0,0,8'h00,12'h000,12'h000,4'd0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.pc", 32'(bus.pc), 32'h0);
    cmp("reset.depth", 32'(bus.stack_depth), 32'h0);
    cmp("reset.flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    //             st ss sc so p1 pu po off    jmp      pc       dep
    tbl.push_back(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h001,4'd0));
    tbl.push_back(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h002,4'd0));
    tbl.push_back(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h003,4'd0));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h010,12'h010,4'd0));
    tbl.push_back(v(0,0,0,1,0,0,0,8'hFC,12'h000,12'h00C,4'd0));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h010,12'h010,4'd0));
    tbl.push_back(v(0,0,0,1,0,0,0,8'h05,12'h000,12'h015,4'd0));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h020,12'h020,4'd0));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h100,12'h100,4'd1));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h021,4'd0));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h001,12'h001,4'd0));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h100,12'h100,4'd1));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h101,12'h101,4'd1));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h200,12'h200,4'd2));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'h201,12'h201,4'd2));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h300,12'h300,4'd3));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h202,4'd2));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h102,4'd1));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h002,4'd0));
    tbl.push_back(v(0,0,0,0,0,0,0,8'h00,12'h000,12'h002,4'd0));
    tbl.push_back(v(1,0,1,0,0,1,0,8'h00,12'h300,12'h002,4'd0));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h300,12'h300,4'd1));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h003,4'd0));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h050,12'h050,4'd1));
    tbl.push_back(v(0,1,1,1,1,0,1,8'h01,12'h777,12'h004,4'd0));
    tbl.push_back(v(0,0,1,1,1,0,0,8'h01,12'h123,12'h123,4'd0));
    tbl.push_back(v(0,0,0,1,1,0,0,8'h02,12'h000,12'h125,4'd0));
    tbl.push_back(v(0,0,1,0,0,0,0,8'h00,12'hFFF,12'hFFF,4'd0));
    tbl.push_back(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h000,4'd0));
    tbl.push_back(v(0,0,0,1,0,0,0,8'hFF,12'h000,12'hFFF,4'd0));
    tbl.push_back(v(0,0,0,1,0,0,0,8'h01,12'h000,12'h000,4'd0));
    tbl.push_back(v(0,0,1,0,0,1,0,8'h00,12'h010,12'h010,4'd1));
    tbl.push_back(v(0,1,0,0,0,1,1,8'h00,12'h000,12'h001,4'd1));
    tbl.push_back(v(0,1,0,0,0,0,1,8'h00,12'h000,12'h011,4'd0));
    do_reset();
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    // asynchronous reset mid-cycle, with a jump and push pending on the inputs
    step(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h012,4'd0), "pre_rst");
    drive(v(0,0,1,0,0,1,0,8'h00,12'h555,12'h000,4'd0));
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst.pc", 32'(bus.pc), 32'h0);
    cmp("async_rst.depth", 32'(bus.stack_depth), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D; i++)
      step(v(0,0,0,0,1,1,0,8'h00,12'h000,AW'(i + 1),G ? 4'(i + 1) : 4'((i + 1) % D)), $sformatf("push%0d", i));
    step(v(0,0,0,0,1,1,0,8'h00,12'h000,12'h009,G ? 4'd8 : 4'd1,G,1'b0), "push_ovf");
    step(v(0,1,0,0,0,0,1,8'h00,12'h000,G ? 12'h008 : 12'h009,G ? 4'd7 : 4'd0,G,1'b0), "pop_after_ovf");
    do_reset();
    step(v(0,0,0,0,1,0,0,8'h00,12'h000,12'h001,4'd0), "pre_empty");
    step(v(0,1,0,0,0,0,1,8'h00,12'h000,G ? 12'h002 : 12'h000,G ? 4'd0 : 4'd7,1'b0,G), "pop_empty");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
